// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtraction sequencer.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_sub_cell.sv
// Combinational full subtractor built from two half-subtractor stages and an OR on the borrows.
module sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  always_comb begin
    d1   = x ^ y;
    b1   = ~x & y;
    d    = d1 ^ bin;
    b2   = ~d1 & bin;
    bout = b1 | b2;
  end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a-b sequencer: one subtractor cell, LSB first, registered borrow.
// Optional saturating mode (diff forced to 0 on final borrow) via SERIAL_SUB_SAT_EN.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic               brw_q, brw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_out_q, borrow_out_d;

  logic               cell_d;
  logic               cell_bout;
  logic               last_bit;
  logic [WIDTH-1:0]   res_next;

  sub_cell u_cell (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .bin  (brw_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign res_next = {cell_d, res_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      brw_q        <= 1'b0;
      cnt_q        <= '0;
      res_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      brw_q        <= brw_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working result lives in res_q so diff keeps the previous answer until the final edge.
  always_comb begin
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    brw_d        = brw_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d = a;
          b_sr_d = b;
          brw_d  = 1'b0;
          cnt_d  = '0;
          res_d  = '0;
        end
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        brw_d  = cell_bout;
        cnt_d  = cnt_q + CNT_W'(1);
        res_d  = res_next;
        if (last_bit) begin
`ifdef SERIAL_SUB_SAT_EN
          diff_d = cell_bout ? '0 : res_next;
`else
          diff_d = res_next;
`endif
          borrow_out_d = cell_bout;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ready      = (state_q == IDLE);
    busy       = (state_q == SHIFT);
    done       = (state_q == DONE);
    diff       = diff_q;
    borrow_out = borrow_out_q;
  end

endmodule
